coin_acceptor: RTL and testbench
================================

COIN_ACCEPTOR -- requirements
Module: coin_acceptor

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 4, consecutive synchronized cycles a sensor level must hold to be taken as stable (legal range 2..255).
REQ-002 Parameter: JAM_CYCLES, default 1000, cycles a sensor may stay high after coin acceptance before a jam is declared (legal range > DEBOUNCE_CYCLES, < 2^16).
REQ-003 Port: clk  input  1  single clock; all state on rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-low reset.
REQ-005 Port: sense_5  input  1  raw, asynchronous, bouncy slot sensor for the 5-unit coin.
REQ-006 Port: sense_10  input  1  raw, asynchronous, bouncy slot sensor for the 10-unit coin.
REQ-007 Port: accept_en  input  1  1 = accept coins; 0 = gate closed, coins rejected.
REQ-008 Port: coin  output  2  coin code to the vending FSM: 00 none, 01 five, 10 ten; 11 never driven.
REQ-009 Port: reject  output  1  one-cycle pulse per rejected insertion.
REQ-010 Port: jam  output  1  level; slot jammed.
REQ-011 Port: coin_cnt  output  8  accepted-coin count, saturating.

Function
REQ-012 sense_5 and sense_10 SHALL each pass through a 2-flop synchronizer; the FSM sees only the synchronized s5 and s10.
REQ-013 FSM states SHALL be IDLE, DEBOUNCE, EMIT, RELEASE, JAM; all outputs registered.
REQ-014 IDLE: exactly one of s5/s10 high -> DEBOUNCE, latch the denomination, load debounce counter = 1; both high -> RELEASE with reject pulse; neither -> stay.
REQ-015 DEBOUNCE: latched sensor high and other low -> increment counter; latched sensor drops or other sensor rises -> IDLE, no coin, no reject (glitch).
REQ-016 DEBOUNCE: counter reaching DEBOUNCE_CYCLES -> EMIT if accept_en = 1, else RELEASE with reject pulse.
REQ-017 EMIT: coin = latched code for exactly one cycle; coin_cnt increments, holding at 255; next state RELEASE.
REQ-018 RELEASE: coin = 00; a 16-bit timer counts cycles in which any synchronized sensor is high; DEBOUNCE_CYCLES consecutive cycles with both low -> IDLE.
REQ-019 RELEASE: timer reaching JAM_CYCLES -> JAM.
REQ-020 JAM: jam = 1, coin = 00, no coin accepted; DEBOUNCE_CYCLES consecutive cycles with both sensors low -> IDLE, jam = 0 on IDLE entry.
REQ-021 Latency: raw sensor held high from edge N (first edge sampling it high) SHALL produce coin != 00 in the cycle following edge N+2+DEBOUNCE_CYCLES.
REQ-022 One physical insertion SHALL yield at most one coin pulse or one reject pulse, never both and never more than one.
REQ-023 accept_en change during DEBOUNCE SHALL be evaluated only at the REQ-016 decision cycle; during RELEASE/JAM it has no effect.
REQ-024 coin SHALL never be nonzero in two consecutive cycles; minimum spacing between coin pulses is 2*DEBOUNCE_CYCLES+2 cycles.

Reset
REQ-025 rst low SHALL immediately force: state IDLE, coin = 00, reject = 0, jam = 0, coin_cnt = 0, synchronizers, counters and timer = 0.
REQ-026 Reset asserted mid-DEBOUNCE, EMIT or JAM SHALL discard the insertion in progress; after release the FSM restarts from IDLE and a still-held sensor is treated as a new insertion.

Verification
REQ-027 DEBOUNCE_CYCLES=4, accept_en=1, sense_5 high from edge 0 for 20 cycles, then low -> coin=01 for one cycle after edge 6, coin_cnt=1, reject never asserted.
REQ-028 sense_10 pulses high 3 cycles, low 2, high 2, then low -> coin stays 00, reject stays 0, FSM back in IDLE.
REQ-029 accept_en=0, sense_10 high 10 cycles -> reject=1 for one cycle after edge 6, coin=00, coin_cnt unchanged.
REQ-030 sense_5 and sense_10 rise on the same edge -> one reject pulse, no coin; next clean sense_5 insertion -> coin=01.
REQ-031 JAM_CYCLES=20, sense_5 held high 40 cycles -> one coin=01, jam=1 after the timer reaches 20; sensor low 4 cycles -> jam=0; next insertion accepted.
REQ-032 coin_cnt preloaded via 255 accepted insertions, one more insertion -> coin pulse still produced, coin_cnt stays 255; rst low mid-DEBOUNCE -> all outputs 0 at once, no coin after release.

Source files
------------

// File: rtl/coin_acceptor.sv
// Coin slot front end: synchronizes and debounces two slot sensors, emits one
// coin code or one reject pulse per insertion, and flags a jammed slot.
module coin_acceptor #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int JAM_CYCLES      = 1000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sense_5,
   input  logic       sense_10,
   input  logic       accept_en,
   output logic [1:0] coin,
   output logic       reject,
   output logic       jam,
   output logic [7:0] coin_cnt
);

   localparam logic [7:0]  DB = 8'(DEBOUNCE_CYCLES);
   localparam logic [15:0] JC = 16'(JAM_CYCLES);

   typedef enum logic [2:0] {IDLE, DEBOUNCE, EMIT, RELEASE, JAM} state_t;

   state_t      r_state, w_state_nxt;
   logic        r_s5_m, r_s5, r_s10_m, r_s10;
   logic        r_den, w_den_nxt;            // 0 = five, 1 = ten
   logic [7:0]  r_dcnt, w_dcnt_nxt;
   logic [15:0] r_timer, w_timer_nxt;
   logic [1:0]  r_coin, w_coin_nxt;
   logic        r_reject, w_reject_nxt;
   logic        r_jam, w_jam_nxt;
   logic [7:0]  r_cnt, w_cnt_nxt;

   logic        w_latched, w_other, w_any;
   logic [7:0]  w_dcnt_inc;
   logic [15:0] w_timer_inc;

   assign w_latched   = r_den ? r_s10 : r_s5;
   assign w_other     = r_den ? r_s5  : r_s10;
   assign w_any       = r_s5 | r_s10;
   assign w_dcnt_inc  = r_dcnt + 8'd1;
   assign w_timer_inc = r_timer + 16'd1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= IDLE;
         r_s5_m   <= 1'b0;
         r_s5     <= 1'b0;
         r_s10_m  <= 1'b0;
         r_s10    <= 1'b0;
         r_den    <= 1'b0;
         r_dcnt   <= '0;
         r_timer  <= '0;
         r_coin   <= 2'b00;
         r_reject <= 1'b0;
         r_jam    <= 1'b0;
         r_cnt    <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_s5_m   <= sense_5;
         r_s5     <= r_s5_m;
         r_s10_m  <= sense_10;
         r_s10    <= r_s10_m;
         r_den    <= w_den_nxt;
         r_dcnt   <= w_dcnt_nxt;
         r_timer  <= w_timer_nxt;
         r_coin   <= w_coin_nxt;
         r_reject <= w_reject_nxt;
         r_jam    <= w_jam_nxt;
         r_cnt    <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_den_nxt    = r_den;
      w_dcnt_nxt   = r_dcnt;
      w_timer_nxt  = r_timer;
      w_coin_nxt   = 2'b00;
      w_reject_nxt = 1'b0;
      w_jam_nxt    = r_jam;
      w_cnt_nxt    = r_cnt;
      case (r_state)
         IDLE: begin
            if (r_s5 ^ r_s10) begin
               w_state_nxt = DEBOUNCE;
               w_den_nxt   = r_s10;
               w_dcnt_nxt  = 8'd1;
            end else if (r_s5 & r_s10) begin
               w_state_nxt  = RELEASE;
               w_reject_nxt = 1'b1;
               w_dcnt_nxt   = '0;
               w_timer_nxt  = '0;
            end
         end
         DEBOUNCE: begin
            // accept_en is only looked at once the level has proven stable
            if (r_dcnt == DB) begin
               w_dcnt_nxt  = '0;
               w_timer_nxt = '0;
               if (accept_en) begin
                  w_state_nxt = EMIT;
                  w_coin_nxt  = r_den ? 2'b10 : 2'b01;
                  if (r_cnt != 8'hFF) w_cnt_nxt = r_cnt + 8'd1;
               end else begin
                  w_state_nxt  = RELEASE;
                  w_reject_nxt = 1'b1;
               end
            end else if (w_latched && !w_other) begin
               w_dcnt_nxt = w_dcnt_inc;
            end else begin
               w_state_nxt = IDLE;
               w_dcnt_nxt  = '0;
            end
         end
         EMIT: begin
            w_state_nxt = RELEASE;
            w_dcnt_nxt  = '0;
            w_timer_nxt = '0;
         end
         RELEASE: begin
            if (w_any) begin
               w_dcnt_nxt  = '0;
               w_timer_nxt = w_timer_inc;
               if (w_timer_inc == JC) begin
                  w_state_nxt = JAM;
                  w_jam_nxt   = 1'b1;
               end
            end else if (w_dcnt_inc == DB) begin
               w_state_nxt = IDLE;
               w_dcnt_nxt  = '0;
            end else begin
               w_dcnt_nxt = w_dcnt_inc;
            end
         end
         JAM: begin
            if (w_any) begin
               w_dcnt_nxt = '0;
            end else if (w_dcnt_inc == DB) begin
               w_state_nxt = IDLE;
               w_jam_nxt   = 1'b0;
               w_dcnt_nxt  = '0;
            end else begin
               w_dcnt_nxt = w_dcnt_inc;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign coin     = r_coin;
   assign reject   = r_reject;
   assign jam      = r_jam;
   assign coin_cnt = r_cnt;

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor: insertion-level reference model compared
// every cycle, plus literal checkpoints at hand-derived cycles.
module tb_coin_acceptor;

   localparam int D = 4;
   localparam int J = 20;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       sense_5 = 1'b0;
   logic       sense_10 = 1'b0;
   logic       accept_en = 1'b1;
   logic [1:0] coin;
   logic       reject;
   logic       jam;
   logic [7:0] coin_cnt;

   int n_cmp = 0;
   int n_bad = 0;
   int n_coin_seen = 0;
   int n_rej_seen = 0;

   coin_acceptor #(.DEBOUNCE_CYCLES(D), .JAM_CYCLES(J)) dut (
      .clk(clk), .rst(rst), .sense_5(sense_5), .sense_10(sense_10),
      .accept_en(accept_en), .coin(coin), .reject(reject), .jam(jam),
      .coin_cnt(coin_cnt)
   );

   always #5 clk = ~clk;

   // Reference: an insertion is a run of samples where exactly one sensor is
   // high; D such samples make it stable, the next edge delivers the verdict,
   // then the slot must go quiet for D samples before a new insertion counts.
   bit         m_a5, m_b5, m_a10, m_b10;
   int         m_run, m_quiet, m_hi;
   bit         m_cand, m_wait, m_skip;
   logic [1:0] m_coin;
   bit         m_rej, m_jam;
   int         m_cnt;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_a5 = 0; m_b5 = 0; m_a10 = 0; m_b10 = 0;
         m_run = 0; m_quiet = 0; m_hi = 0;
         m_cand = 0; m_wait = 0; m_skip = 0;
         m_coin = 0; m_rej = 0; m_jam = 0; m_cnt = 0;
      end else begin
         m_coin = 0;
         m_rej  = 0;
         if (m_skip) begin
            m_skip = 0;
         end else if (m_wait) begin
            if (m_b5 || m_b10) begin
               m_quiet = 0;
               m_hi++;
               if (m_hi == J) m_jam = 1;
            end else begin
               m_quiet++;
               if (m_quiet == D) begin m_wait = 0; m_jam = 0; m_quiet = 0; end
            end
         end else if (m_run == D) begin
            if (accept_en) begin
               m_coin = m_cand ? 2'd2 : 2'd1;
               if (m_cnt < 255) m_cnt++;
               m_skip = 1;
            end else begin
               m_rej = 1;
            end
            m_wait = 1; m_hi = 0; m_quiet = 0; m_run = 0;
         end else if (m_run > 0) begin
            if ((m_cand ? m_b10 : m_b5) && !(m_cand ? m_b5 : m_b10)) m_run++;
            else m_run = 0;
         end else if (m_b5 && m_b10) begin
            m_rej = 1; m_wait = 1; m_hi = 0; m_quiet = 0;
         end else if (m_b5 || m_b10) begin
            m_cand = m_b10;
            m_run  = 1;
         end
         m_b5 = m_a5;  m_a5 = sense_5;
         m_b10 = m_a10; m_a10 = sense_10;
      end
   end

   logic [1:0] prev_coin = 2'b00;
   always @(negedge clk) begin
      n_cmp++;
      if (coin !== m_coin || reject !== m_rej || jam !== m_jam || coin_cnt !== 8'(m_cnt)) begin
         n_bad++;
         $display("FAIL model t=%0t: got coin=%0d rej=%0d jam=%0d cnt=%0d, expected coin=%0d rej=%0d jam=%0d cnt=%0d",
                  $time, coin, reject, jam, coin_cnt, m_coin, m_rej, m_jam, m_cnt);
      end
      if (coin != 2'b00) begin
         n_cmp++;
         if (coin == 2'b11 || prev_coin != 2'b00 || reject) begin
            n_bad++;
            $display("FAIL coin_rules t=%0t: coin=%0d prev=%0d rej=%0d", $time, coin, prev_coin, reject);
         end
      end
      if (coin != 2'b00) n_coin_seen++;
      if (reject) n_rej_seen++;
      prev_coin = coin;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic insert(input bit ten, input int hi, input int lo);
      if (ten) sense_10 = 1'b1; else sense_5 = 1'b1;
      repeat (hi) tick();
      sense_5 = 1'b0; sense_10 = 1'b0;
      repeat (lo) tick();
   endtask

   int c0, r0;

   initial begin
      repeat (3) tick();
      chk("reset_coin", int'(coin), 0);
      chk("reset_cnt", int'(coin_cnt), 0);
      chk("reset_jam_rej", int'({jam, reject}), 0);
      rst = 1'b1;
      repeat (3) tick();

      // Clean five: raw high from edge 0, coin exactly after edge 6
      sense_5 = 1'b1;
      for (int e = 0; e < 20; e++) begin
         tick();
         if (e >= 5 && e <= 7) chk($sformatf("five_coin_e%0d", e), int'(coin), (e == 6) ? 1 : 0);
      end
      sense_5 = 1'b0;
      repeat (8) tick();
      chk("five_cnt", int'(coin_cnt), 1);

      // Bouncy ten: never stable long enough
      c0 = n_coin_seen; r0 = n_rej_seen;
      sense_10 = 1'b1; repeat (3) tick();
      sense_10 = 1'b0; repeat (2) tick();
      sense_10 = 1'b1; repeat (2) tick();
      sense_10 = 1'b0; repeat (8) tick();
      chk("bounce_pulses", n_coin_seen - c0 + n_rej_seen - r0, 0);
      chk("bounce_cnt", int'(coin_cnt), 1);

      // Gate closed: reject after edge 6
      accept_en = 1'b0;
      sense_10 = 1'b1;
      for (int e = 0; e < 10; e++) begin
         tick();
         if (e >= 5 && e <= 7) chk($sformatf("gate_rej_e%0d", e), int'(reject), (e == 6) ? 1 : 0);
      end
      sense_10 = 1'b0;
      repeat (8) tick();
      accept_en = 1'b1;
      chk("gate_cnt", int'(coin_cnt), 1);

      // Both sensors together: reject after edge 2, then a clean five
      sense_5 = 1'b1; sense_10 = 1'b1;
      for (int e = 0; e < 6; e++) begin
         tick();
         if (e == 2) chk("both_rej_e2", int'(reject), 1);
      end
      sense_5 = 1'b0; sense_10 = 1'b0;
      repeat (8) tick();
      c0 = n_coin_seen;
      insert(1'b0, 8, 8);
      chk("after_both_coin", n_coin_seen - c0, 1);
      chk("after_both_cnt", int'(coin_cnt), 2);

      // Jam: sensor stuck 40 cycles
      sense_5 = 1'b1;
      for (int e = 0; e < 40; e++) begin
         tick();
         if (e == 6) chk("jam_coin_e6", int'(coin), 1);
         if (e == 26) chk("jam_e26", int'(jam), 0);
         if (e == 27) chk("jam_e27", int'(jam), 1);
      end
      sense_5 = 1'b0;
      for (int e = 40; e < 48; e++) begin
         tick();
         if (e == 44) chk("jam_e44", int'(jam), 1);
         if (e == 45) chk("jam_e45", int'(jam), 0);
      end
      insert(1'b1, 8, 8);
      chk("post_jam_cnt", int'(coin_cnt), 4);

      // Saturate the counter, then one more insertion still pulses
      for (int i = 0; i < 251; i++) insert(i[0], 8, 8);
      chk("sat_cnt", int'(coin_cnt), 255);
      c0 = n_coin_seen;
      insert(1'b0, 8, 8);
      chk("sat_pulse", n_coin_seen - c0, 1);
      chk("sat_hold", int'(coin_cnt), 255);

      // Reset mid-debounce with sensor then released: nothing emitted
      sense_5 = 1'b1;
      repeat (4) tick();
      rst = 1'b0;
      #1;
      chk("rst_now_cnt", int'(coin_cnt), 0);
      chk("rst_now_outs", int'({coin, reject, jam}), 0);
      sense_5 = 1'b0;
      repeat (3) tick();
      rst = 1'b1;
      c0 = n_coin_seen;
      repeat (12) tick();
      chk("rst_no_coin", n_coin_seen - c0, 0);

      // Reset with sensor still held: a fresh insertion after release
      sense_10 = 1'b1;
      repeat (4) tick();
      rst = 1'b0;
      repeat (2) tick();
      rst = 1'b1;
      c0 = n_coin_seen;
      repeat (10) tick();
      sense_10 = 1'b0;
      repeat (10) tick();
      chk("rst_held_coin", n_coin_seen - c0, 1);
      chk("rst_held_cnt", int'(coin_cnt), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
